// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lends one combinational ALU to two requesters.
// Each granted operation walks IDLE -> EXEC -> RESP with valid/ready on both sides.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,
    output logic              resp_valid_o,
    output logic              resp_id_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_zero_o,
    input  logic              resp_ready_i,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_zero_q, resp_zero_d;

    logic grant;
    logic accept;

    // Contention is settled by the pointer; a lone requester always wins.
    assign grant        = (req0_valid_i & req1_valid_i) ? ptr_q : req1_valid_i;
    assign req0_ready_o = (state_q == IDLE) & req0_valid_i & ~grant;
    assign req1_ready_o = (state_q == IDLE) & req1_valid_i & grant;
    assign accept       = req0_ready_o | req1_ready_o;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        ctrl_d       = ctrl_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_zero_d  = resp_zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = grant;
                    ptr_d   = ~grant;
                    ctrl_d  = grant ? req1_ctrl_i : req0_ctrl_i;
                    src1_d  = grant ? req1_src1_i : req0_src1_i;
                    src2_d  = grant ? req1_src2_i : req0_src2_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = alu_result_i;
                resp_zero_d  = alu_zero_i;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            id_q         <= 1'b0;
            ctrl_q       <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            ctrl_q       <= ctrl_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_zero_q  <= resp_zero_d;
        end
    end

    // The ALU only ever sees operands that were actually accepted.
    assign alu_ctrl_o   = ctrl_q;
    assign alu_src1_o   = src1_q;
    assign alu_src2_o   = src2_q;

    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_data_o  = resp_data_q;
    assign resp_zero_o  = resp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: stimulus pushes expected responses,
// a monitor pops and compares each consumed response.
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req0_ready;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [DATA_W-1:0] req0_src1, req0_src2;
    logic              req1_valid, req1_ready;
    logic [CTRL_W-1:0] req1_ctrl;
    logic [DATA_W-1:0] req1_src1, req1_src2;
    logic              resp_valid, resp_id, resp_zero, resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_src1, alu_src2, alu_result;
    logic              alu_zero;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
        logic              zero;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_ctrl_i  (req0_ctrl),
        .req0_src1_i  (req0_src1),
        .req0_src2_i  (req0_src2),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_ctrl_i  (req1_ctrl),
        .req1_src1_i  (req1_src1),
        .req1_src2_i  (req1_src2),
        .resp_valid_o (resp_valid),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
        .resp_zero_o  (resp_zero),
        .resp_ready_i (resp_ready),
        .alu_ctrl_o   (alu_ctrl),
        .alu_src1_o   (alu_src1),
        .alu_src2_o   (alu_src2),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple ALU: and / or / add / sub
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b0010: alu_result = alu_src1 + alu_src2;
            4'b0110: alu_result = alu_src1 - alu_src2;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every consumed response must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: actual id=%0d data=%0h required none", resp_id, resp_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_id", {63'd0, resp_id}, {63'd0, e.id});
                check("resp_data", {32'd0, resp_data}, {32'd0, e.data});
                check("resp_zero", {63'd0, resp_zero}, {63'd0, e.zero});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_accept(input logic exp_id, input logic [DATA_W-1:0] d,
                                 input logic z, input bit push, input string name);
        bit found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) found = 1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: actual no ready required ready within 20 cycles", name);
            return;
        end
        check({name, "_grant"}, {63'd0, req1_ready}, {63'd0, exp_id});
        check({name, "_one_ready"}, {63'd0, req0_ready & req1_ready}, 64'd0);
        acc_cyc = cyc;
        if (push) sb_q.push_back('{id: exp_id, data: d, zero: z});
        tick();
    endtask

    initial begin
        int prev_acc;
        int rise_cyc;
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_ctrl = '0; req0_src1 = '0; req0_src2 = '0;
        req1_valid = 1'b0; req1_ctrl = '0; req1_src1 = '0; req1_src2 = '0;
        resp_ready = 1'b0;
        #3;
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data", {32'd0, resp_data}, 64'd0);
        check("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        check("rst_alu_src1", {32'd0, alu_src1}, 64'd0);
        #9 rst_n = 1'b1;
        tick();

        // Single add on requester 0
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_src1 = 32'd5; req0_src2 = 32'd7;
        expect_accept(1'b0, 32'd12, 1'b0, 1, "t1");
        req0_valid = 1'b0;
        check("t1_alu_ctrl", {60'd0, alu_ctrl}, 64'h2);
        check("t1_alu_src2", {32'd0, alu_src2}, 64'd7);
        check("t1_exec_valid", {63'd0, resp_valid}, 64'd0);
        tick();
        check("t1_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("t1_resp_data", {32'd0, resp_data}, 64'hC);
        tick();
        check("t1_consumed", {63'd0, resp_valid}, 64'd0);

        // Backpressure on requester 1 (pointer now 1)
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_ctrl = 4'b0010; req1_src1 = 32'd1; req1_src2 = 32'd2;
        expect_accept(1'b1, 32'd3, 1'b0, 1, "t3a");
        req1_src1 = 32'd10; req1_src2 = 32'd20;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", {63'd0, resp_valid}, 64'd1);
            check("t3_hold_data", {32'd0, resp_data}, 64'd3);
            check("t3_hold_id", {63'd0, resp_id}, 64'd1);
            check("t3_no_ready1", {63'd0, req1_ready}, 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        rise_cyc = cyc;
        tick();
        expect_accept(1'b1, 32'd30, 1'b0, 1, "t3b");
        check("t3_accept_after_ready", acc_cyc, rise_cyc + 1);
        req1_valid = 1'b0;
        repeat (3) tick();

        // Fairness with both valid (pointer now 0)
        req0_valid = 1'b1; req0_ctrl = 4'b0110; req0_src1 = 32'd9;    req0_src2 = 32'd9;
        req1_valid = 1'b1; req1_ctrl = 4'b0001; req1_src1 = 32'hF0; req1_src2 = 32'h0F;
        prev_acc = 0;
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) expect_accept(1'b0, 32'd0, 1'b1, 1, "t2");
            else            expect_accept(1'b1, 32'hFF, 1'b0, 1, "t2");
            if (g > 0) check("t2_spacing", acc_cyc - prev_acc, 3);
            prev_acc = acc_cyc;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();

        // Operand change after accept
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_src1 = 32'd3; req0_src2 = 32'd4;
        expect_accept(1'b0, 32'd7, 1'b0, 1, "t4");
        req0_src1 = 32'd100; req0_valid = 1'b0;
        check("t4_alu_src1_latched", {32'd0, alu_src1}, 64'd3);
        repeat (3) tick();

        // Idle: nothing happens, pointer (1) retained
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_idle_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
            check("t6_idle_valid", {63'd0, resp_valid}, 64'd0);
        end
        tick();
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_src1 = 32'd1; req0_src2 = 32'd1;
        req1_valid = 1'b1; req1_ctrl = 4'b0010; req1_src1 = 32'd2; req1_src2 = 32'd2;
        expect_accept(1'b1, 32'd4, 1'b0, 1, "t6");
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();

        // Asynchronous reset during EXEC; pointer was 1 before reset
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_src1 = 32'd50; req0_src2 = 32'd50;
        expect_accept(1'b0, 32'd100, 1'b0, 0, "t5a");
        req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {63'd0, resp_valid}, 64'd0);
        check("t5_rst_data", {32'd0, resp_data}, 64'd0);
        check("t5_rst_id", {63'd0, resp_id}, 64'd0);
        check("t5_rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        check("t5_rst_alu_src1", {32'd0, alu_src1}, 64'd0);
        check("t5_rst_alu_src2", {32'd0, alu_src2}, 64'd0);
        tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_resp", {63'd0, resp_valid}, 64'd0);
        end
        tick();
        req0_valid = 1'b1; req0_ctrl = 4'b0110; req0_src1 = 32'd20; req0_src2 = 32'd5;
        req1_valid = 1'b1; req1_ctrl = 4'b0010; req1_src1 = 32'd1;  req1_src2 = 32'd2;
        expect_accept(1'b0, 32'd15, 1'b0, 1, "t5b");
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();

        check("sb_empty", sb_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: actual time limit reached required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (4-bit ALU control code, two operands, result and zero flag) between two requesters.
- Typical requesters: the main datapath and a helper unit such as a branch-compare or address unit.
- Round-robin arbitration; each accepted request runs a fixed 3-state sequence (accept, execute, respond) with valid/ready handshakes on both sides.
- Sits between the requesters and the ALU; drives the ALU control code and operands directly.

Parameters:
DATA_W, 32, operand/result width
CTRL_W, 4, ALU control code width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
req0_valid_i  input  1  requester 0 has an operation
req0_ready_o  output  1  requester 0 operation accepted this cycle
req0_ctrl_i  input  CTRL_W  requester 0 ALU control code
req0_src1_i  input  DATA_W  requester 0 operand 1
req0_src2_i  input  DATA_W  requester 0 operand 2
req1_valid_i, req1_ready_o, req1_ctrl_i, req1_src1_i, req1_src2_i  same as requester 0, for requester 1
resp_valid_o  output  1  response available
resp_id_o  output  1  requester owning the response
resp_data_o  output  DATA_W  captured ALU result
resp_zero_o  output  1  captured ALU zero flag
resp_ready_i  input  1  owner consumes response
alu_ctrl_o  output  CTRL_W  control code to ALU
alu_src1_o  output  DATA_W  operand 1 to ALU
alu_src2_o  output  DATA_W  operand 2 to ALU
alu_result_i  input  DATA_W  ALU result (combinational)
alu_zero_i  input  1  ALU zero flag

Behaviour:
- Reset (rst_i low, asynchronous):
  - State returns to IDLE.
  - Priority pointer = 0.
  - All latched registers cleared.
  - resp_valid_o=0, resp_id_o=0, resp_data_o=0, resp_zero_o=0.
  - alu_ctrl_o/src1/src2 = 0.
  - Reset mid-operation discards any in-flight operation; no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule:
    - only req0 valid -> grant 0
    - only req1 valid -> grant 1
    - both valid -> grant the pointer's requester
  - reqK_ready_o = (state==IDLE) & reqK_valid_i & grant==K, combinational. At most one ready is high at a time.
  - On accept: latch ctrl/src1/src2 and id; set pointer = ~id; go to EXEC.
  - No valid request -> stay in IDLE; pointer unchanged.
- EXEC (exactly 1 cycle):
  - alu_* outputs driven from the latched registers.
  - At the clock edge: resp_data_o <= alu_result_i, resp_zero_o <= alu_zero_i, resp_id_o <= latched id, resp_valid_o <= 1; go to RESP.
- RESP:
  - resp_valid_o held at 1; resp_data_o, resp_zero_o, resp_id_o held stable.
  - resp_ready_i=1 -> resp_valid_o <= 0, go to IDLE. A new accept is possible on the following cycle.
  - resp_ready_i=0 -> stay in RESP indefinitely. No new request is accepted (both ready outputs low).
- alu_* outputs in IDLE and RESP: hold the last latched values. The ALU is never driven with unaccepted requester data.
- Latency:
  - Accept at edge N.
  - Result captured and resp_valid_o high after edge N+1.
  - Earliest consume at edge N+2.
  - Back-to-back throughput: one operation per 3 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1... The first grant after reset goes to 0.
- Request inputs are sampled only at the accept edge. Changes in EXEC or RESP have no effect on the operation in flight.
- Widths: data passes through unchanged; no extension or truncation.

Test Plan:
- Reset, then req0 only, ctrl=0010, src1=5, src2=7 -> req0_ready_o=1 in the accept cycle; alu_ctrl_o=0010 in EXEC; 2 cycles later resp_valid_o=1, resp_id_o=0, resp_data_o=12 (0x0000000C), resp_zero_o=0; consumed with resp_ready_i=1.
- req0 and req1 both held valid, req0 sub 9-9, req1 or 0xF0|0x0F, resp_ready_i=1 -> grants 0,1,0,1:
  - req0 responses: data=0, zero=1
  - req1 responses: data=0xFF, zero=0
  - accepts spaced exactly 3 cycles apart.
- Response backpressure: resp_ready_i=0 for 5 cycles with req1 valid -> resp_valid_o held with stable data; req1_ready_o stays 0; accept occurs the cycle after resp_ready_i rises.
- Operand change after accept: req0 src1 changed from 3 to 100 during EXEC, add src2=4 -> resp_data_o=7.
- rst_i asserted low asynchronously during EXEC -> outputs clear immediately without a clock edge; no response appears after release; the first grant after release goes to req0 even if req1 is also valid.
- Both requesters idle for 10 cycles -> no ready, no resp_valid_o; the pointer keeps its last value (verify with a subsequent simultaneous request).
